// File: rtl/v_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : v_sync_gen
// Brief    : Vertical line counter and VGA sync / display-enable generator
//            for 640x480@60, clocked by the horizontal line-end pulse.
// Revision : 1.0 - initial release
// ============================================================================
module v_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic       trig_V,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick,
    output logic       line_err
);

    localparam logic [9:0] c_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0] c_H_TOTAL    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VACT_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] c_VFP_LAST   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] c_VSYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {
        V_ACT  = 2'd0,
        V_FPO  = 2'd1,
        V_SYN  = 2'd2,
        V_BPO  = 2'd3
    } v_state_t;

    v_state_t   r_state;
    logic [9:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_frame_tick;
    logic       r_line_err;
    logic       r_armed;

    logic       w_h_in_line;
    logic       w_h_sync_zone;
    logic       w_h_visible;
    logic       w_h_zero;

    // Out-of-range columns (>= H_TOTAL) never count as sync or visible.
    assign w_h_in_line   = (hcount < c_H_TOTAL);
    assign w_h_sync_zone = w_h_in_line && (hcount >= c_HS_FIRST) && (hcount <= c_HS_LAST);
    assign w_h_visible   = w_h_in_line && (hcount < c_H_ACTIVE);
    assign w_h_zero      = (hcount == 10'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= V_ACT;
            r_vcount     <= 10'd0;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_video_on   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_line_err   <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_hsync      <= w_h_sync_zone ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= (r_state == V_SYN) ? SYNC_POL : ~SYNC_POL;
            r_video_on   <= w_h_visible && (r_state == V_ACT);
            r_frame_tick <= trig_V && (r_vcount == c_V_LAST);

            // A trigger off column 0, or a missing one at column 0, is flagged
            // but never resynchronised: the count simply follows trig_V.
            if ((trig_V && !w_h_zero) || (r_armed && w_h_zero && !trig_V)) begin
                r_line_err <= 1'b1;
            end
            if (trig_V) begin
                r_armed <= 1'b1;
            end

            if (trig_V) begin
                r_vcount <= (r_vcount == c_V_LAST) ? 10'd0 : r_vcount + 10'd1;
                case (r_state)
                    V_ACT:   if (r_vcount == c_VACT_LAST)  r_state <= V_FPO;
                    V_FPO:   if (r_vcount == c_VFP_LAST)   r_state <= V_SYN;
                    V_SYN:   if (r_vcount == c_VSYNC_LAST) r_state <= V_BPO;
                    V_BPO:   if (r_vcount == c_V_LAST)     r_state <= V_ACT;
                    default: r_state <= V_ACT;
                endcase
            end
        end
    end

    assign vcount     = r_vcount;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign frame_tick = r_frame_tick;
    assign line_err   = r_line_err;

endmodule
`default_nettype wire
